// File: rtl/console_uart.sv
// Console UART for the CPU reg_div/reg_dat handshake: 8N1 transmitter, synchronised
// receiver and a small RX FIFO that the CPU pops through reg_dat.
module console_uart #(
  parameter int unsigned DEFAULT_DIV = 53333,
  parameter int unsigned RX_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        ser_tx,
  input  logic        ser_rx,
  input  logic [3:0]  reg_div_we,
  input  logic [31:0] reg_div_di,
  output logic [31:0] reg_div_do,
  input  logic        reg_dat_we,
  input  logic        reg_dat_re,
  input  logic [31:0] reg_dat_di,
  output logic [31:0] reg_dat_do,
  output logic        reg_dat_wait,
  output logic        rx_overrun
);

  localparam int unsigned AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

  // ---------------------------------------------------------------- divider
  logic [31:0] r_div;
  logic [31:0] w_eff_div;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_div <= 32'(DEFAULT_DIV);
    end else begin
      for (int unsigned n = 0; n < 4; n++) begin
        if (reg_div_we[n]) r_div[8*n +: 8] <= reg_div_di[8*n +: 8];
      end
    end
  end

  assign w_eff_div  = (r_div < 32'd2) ? 32'd2 : r_div;
  assign reg_div_do = r_div;

  // ---------------------------------------------------------------- transmitter
  tx_state_t   r_tx_state, w_tx_state_nx;
  logic [31:0] r_tx_div,   w_tx_div_nx;
  logic [31:0] r_tx_cnt,   w_tx_cnt_nx;
  logic [2:0]  r_tx_bit,   w_tx_bit_nx;
  logic [7:0]  r_tx_shift, w_tx_shift_nx;
  logic        r_ser_tx,   w_ser_tx_nx;
  logic        w_tx_bit_end;
  logic        w_tx_busy;
  logic        w_unused_dat;

  assign w_unused_dat = ^reg_dat_di[31:8];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tx_state <= TX_IDLE;
      r_tx_div   <= '0;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_ser_tx   <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nx;
      r_tx_div   <= w_tx_div_nx;
      r_tx_cnt   <= w_tx_cnt_nx;
      r_tx_bit   <= w_tx_bit_nx;
      r_tx_shift <= w_tx_shift_nx;
      r_ser_tx   <= w_ser_tx_nx;
    end
  end

  assign w_tx_bit_end = (r_tx_cnt == r_tx_div - 32'd1);

  always_comb begin
    w_tx_state_nx = r_tx_state;
    w_tx_div_nx   = r_tx_div;
    w_tx_cnt_nx   = r_tx_cnt + 32'd1;
    w_tx_bit_nx   = r_tx_bit;
    w_tx_shift_nx = r_tx_shift;
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_cnt_nx = '0;
        if (reg_dat_we) begin
          w_tx_state_nx = TX_START;
          w_tx_div_nx   = w_eff_div;
          w_tx_bit_nx   = '0;
          w_tx_shift_nx = reg_dat_di[7:0];
        end
      end
      TX_START: begin
        if (w_tx_bit_end) begin
          w_tx_state_nx = TX_DATA;
          w_tx_cnt_nx   = '0;
        end
      end
      TX_DATA: begin
        if (w_tx_bit_end) begin
          w_tx_cnt_nx   = '0;
          w_tx_shift_nx = {1'b0, r_tx_shift[7:1]};
          w_tx_bit_nx   = r_tx_bit + 3'd1;
          if (r_tx_bit == 3'd7) w_tx_state_nx = TX_STOP;
        end
      end
      TX_STOP: begin
        if (w_tx_bit_end) begin
          w_tx_state_nx = TX_IDLE;
          w_tx_cnt_nx   = '0;
        end
      end
      default: w_tx_state_nx = TX_IDLE;
    endcase
  end

  // Line level is registered from the next state so it changes exactly at bit boundaries.
  always_comb begin
    w_ser_tx_nx = 1'b1;
    case (w_tx_state_nx)
      TX_START: w_ser_tx_nx = 1'b0;
      TX_DATA:  w_ser_tx_nx = w_tx_shift_nx[0];
      default:  w_ser_tx_nx = 1'b1;
    endcase
  end

  assign ser_tx       = r_ser_tx;
  assign w_tx_busy    = (r_tx_state != TX_IDLE);
  assign reg_dat_wait = reg_dat_we & w_tx_busy;

  // ---------------------------------------------------------------- receiver
  logic        r_rx_meta, r_rx_sync, r_rx_prev;
  rx_state_t   r_rx_state, w_rx_state_nx;
  logic [31:0] r_rx_div,   w_rx_div_nx;
  logic [31:0] r_rx_cnt,   w_rx_cnt_nx;
  logic [2:0]  r_rx_bit,   w_rx_bit_nx;
  logic [7:0]  r_rx_shift, w_rx_shift_nx;
  logic        w_rx_fall;
  logic        w_rx_push;
  logic [31:0] w_rx_half;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_div   <= '0;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_meta  <= ser_rx;
      r_rx_sync  <= r_rx_meta;
      r_rx_prev  <= r_rx_sync;
      r_rx_state <= w_rx_state_nx;
      r_rx_div   <= w_rx_div_nx;
      r_rx_cnt   <= w_rx_cnt_nx;
      r_rx_bit   <= w_rx_bit_nx;
      r_rx_shift <= w_rx_shift_nx;
    end
  end

  assign w_rx_fall = r_rx_prev & ~r_rx_sync;
  assign w_rx_half = r_rx_div >> 1;

  always_comb begin
    w_rx_state_nx = r_rx_state;
    w_rx_div_nx   = r_rx_div;
    w_rx_cnt_nx   = r_rx_cnt + 32'd1;
    w_rx_bit_nx   = r_rx_bit;
    w_rx_shift_nx = r_rx_shift;
    w_rx_push     = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        w_rx_cnt_nx = '0;
        if (w_rx_fall) begin
          w_rx_state_nx = RX_START;
          w_rx_div_nx   = w_eff_div;
        end
      end
      RX_START: begin
        if (r_rx_cnt == w_rx_half - 32'd1) begin
          w_rx_cnt_nx   = '0;
          w_rx_bit_nx   = '0;
          w_rx_state_nx = r_rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_rx_cnt == r_rx_div - 32'd1) begin
          w_rx_cnt_nx   = '0;
          w_rx_shift_nx = {r_rx_sync, r_rx_shift[7:1]};
          w_rx_bit_nx   = r_rx_bit + 3'd1;
          if (r_rx_bit == 3'd7) w_rx_state_nx = RX_STOP;
        end
      end
      RX_STOP: begin
        if (r_rx_cnt == r_rx_div - 32'd1) begin
          w_rx_cnt_nx = '0;
          if (r_rx_sync) begin
            w_rx_push     = 1'b1;
            w_rx_state_nx = RX_IDLE;
          end else begin
            w_rx_state_nx = RX_BREAK;
          end
        end
      end
      RX_BREAK: begin
        w_rx_cnt_nx = '0;
        if (r_rx_sync) w_rx_state_nx = RX_IDLE;
      end
      default: w_rx_state_nx = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [7:0]    r_mem [RX_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          r_ovr;
  logic          w_full, w_empty, w_pop, w_push_ok;

  assign w_full    = (r_cnt == (AW+1)'(RX_DEPTH));
  assign w_empty   = (r_cnt == '0);
  assign w_pop     = reg_dat_re & ~w_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_push_ok = w_rx_push & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wp] <= r_rx_shift;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovr <= 1'b0;
    end else begin
      if (w_push_ok) r_wp <= r_wp + AW'(1);
      if (w_pop)     r_rp <= r_rp + AW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_rx_push && !w_push_ok) r_ovr <= 1'b1;
    end
  end

  assign reg_dat_do = w_empty ? '0 : {24'd0, r_mem[r_rp]};
  assign rx_overrun = r_ovr;

endmodule

// File: tb/tb_console_uart.sv
// Self-checking bench for console_uart: queued expectations for TX frames and RX pops,
// checked by independent monitors against a behavioural line/FIFO model.
module tb_console_uart;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ser_tx;
  logic        ser_rx = 1'b1;
  logic [3:0]  reg_div_we = '0;
  logic [31:0] reg_div_di = '0;
  logic [31:0] reg_div_do;
  logic        reg_dat_we = 1'b0;
  logic        reg_dat_re = 1'b0;
  logic [31:0] reg_dat_di = '0;
  logic [31:0] reg_dat_do;
  logic        reg_dat_wait;
  logic        rx_overrun;

  always #5 clk = ~clk;

  console_uart #(.DEFAULT_DIV(53333), .RX_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .ser_tx(ser_tx), .ser_rx(ser_rx),
    .reg_div_we(reg_div_we), .reg_div_di(reg_div_di), .reg_div_do(reg_div_do),
    .reg_dat_we(reg_dat_we), .reg_dat_re(reg_dat_re), .reg_dat_di(reg_dat_di),
    .reg_dat_do(reg_dat_do), .reg_dat_wait(reg_dat_wait), .rx_overrun(rx_overrun)
  );

  int          total = 0;
  int          bad = 0;
  logic [7:0]  txq[$];
  logic [7:0]  rxq[$];
  logic        exp_ovr = 1'b0;
  int unsigned cur_div = 53333;
  int          rst_events = 0;

  always @(negedge resetn) rst_events++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_div(input logic [3:0] we, input logic [31:0] v);
    reg_div_we = we;
    reg_div_di = v;
    tick();
    reg_div_we = '0;
  endtask

  task automatic set_div(input int unsigned d);
    write_div(4'hF, d);
    cur_div = (d < 2) ? 2 : d;
  endtask

  task automatic send_tx(input logic [7:0] b);
    int unsigned n;
    n = 0;
    txq.push_back(b);
    reg_dat_di = {24'($urandom), b};
    reg_dat_we = 1'b1;
    @(negedge clk);
    while (reg_dat_wait && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("tx_accept_wait", {31'd0, reg_dat_wait}, 32'd0);
    @(posedge clk);
    #1 reg_dat_we = 1'b0;
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stopb, input int unsigned d);
    ser_rx = 1'b0;
    repeat (d) tick();
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      repeat (d) tick();
    end
    ser_rx = stopb;
    repeat (d) tick();
    ser_rx = 1'b1;
  endtask

  task automatic rx_model_push(input logic [7:0] b);
    if (rxq.size() < DEPTH) rxq.push_back(b);
    else exp_ovr = 1'b1;
  endtask

  task automatic pop_n(input int unsigned n);
    reg_dat_re = 1'b1;
    repeat (n) tick();
    reg_dat_re = 1'b0;
  endtask

  // RX pop monitor: every cycle the CPU pops, the visible head must match the model.
  logic [31:0] rx_exp;
  always @(negedge clk) begin
    if (resetn && reg_dat_re) begin
      rx_exp = '0;
      if (rxq.size() > 0) rx_exp = {24'd0, rxq.pop_front()};
      chk("rx_pop_data", reg_dat_do, rx_exp);
    end
  end

  // TX line monitor: decodes 8N1 at mid-bit and compares against queued writes.
  initial begin : tx_mon
    int unsigned d;
    int          r0;
    logic [7:0]  b;
    logic        st, sp;
    logic [7:0]  e;
    forever begin
      @(negedge clk);
      if (resetn && ser_tx === 1'b0) begin
        d  = cur_div;
        r0 = rst_events;
        repeat (d / 2) @(negedge clk);
        st = ser_tx;
        for (int i = 0; i < 8; i++) begin
          repeat (d) @(negedge clk);
          b[i] = ser_tx;
        end
        repeat (d) @(negedge clk);
        sp = ser_tx;
        if (rst_events != r0) begin
          if (txq.size() > 0) void'(txq.pop_front());
        end else begin
          chk("tx_frame_expected", {31'd0, txq.size() > 0}, 32'd1);
          if (txq.size() > 0) begin
            e = txq.pop_front();
            chk("tx_byte", {24'd0, b}, {24'd0, e});
            chk("tx_start_stop", {30'd0, st, sp}, 32'd1);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : main
    logic [7:0]  a5;
    int          k;
    logic        exp_bit;
    int unsigned d;
    logic [7:0]  tb_b, rb;
    int unsigned np;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ser_tx", {31'd0, ser_tx}, 32'd1);
    chk("rst_div", reg_div_do, 32'd53333);
    chk("rst_dat_do", reg_dat_do, 32'd0);
    chk("rst_wait", {31'd0, reg_dat_wait}, 32'd0);
    chk("rst_ovr", {31'd0, rx_overrun}, 32'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    tick();

    // byte-lane divider write: 53333 = 0xD055, lane 1 only
    write_div(4'b0010, 32'h1234_5678);
    chk("div_lane1", reg_div_do, 32'h0000_5655);
    set_div(16);
    chk("div_16", reg_div_do, 32'd16);

    // directed 0xA5 frame with reg_dat_we held three cycles past accept
    a5 = 8'hA5;
    txq.push_back(a5);
    reg_dat_di = 32'h0000_00A5;
    reg_dat_we = 1'b1;
    @(negedge clk);
    chk("wait_on_accept", {31'd0, reg_dat_wait}, 32'd0);
    chk("tx_idle_high", {31'd0, ser_tx}, 32'd1);
    for (int j = 0; j <= 160; j++) begin
      @(negedge clk);
      k = j / 16;
      if (k == 0) exp_bit = 1'b0;
      else if (k <= 8) exp_bit = a5[k-1];
      else exp_bit = 1'b1;
      chk("tx_a5_bit", {31'd0, ser_tx}, {31'd0, exp_bit});
      if (j <= 3) chk("wait_held", {31'd0, reg_dat_wait}, 32'd1);
      if (j == 4) chk("wait_released", {31'd0, reg_dat_wait}, 32'd0);
      if (j == 3) reg_dat_we = 1'b0;
    end
    @(posedge clk);
    #1;
    repeat (20) tick();

    // single received byte, then one-cycle pop
    rx_frame(8'h3C, 1'b1, 16);
    rx_model_push(8'h3C);
    chk("rx_head_3c", reg_dat_do, 32'h3C);
    pop_n(1);
    chk("rx_empty_after_pop", reg_dat_do, 32'd0);

    // five bytes into a four-entry FIFO
    for (int i = 1; i <= 5; i++) begin
      rx_frame(8'(i), 1'b1, 16);
      rx_model_push(8'(i));
      repeat (4) tick();
    end
    chk("rx_overrun_set", {31'd0, rx_overrun}, {31'd0, exp_ovr});
    pop_n(2);
    pop_n(1);
    pop_n(1);
    pop_n(1);
    chk("rx_drained", reg_dat_do, 32'd0);

    // glitch, framing error, then a good byte
    ser_rx = 1'b0;
    repeat (6) tick();
    ser_rx = 1'b1;
    repeat (40) tick();
    chk("rx_glitch_no_push", reg_dat_do, 32'd0);
    rx_frame(8'h55, 1'b0, 16);
    repeat (32) tick();
    chk("rx_framing_no_push", reg_dat_do, 32'd0);
    rx_frame(8'h77, 1'b1, 16);
    rx_model_push(8'h77);
    chk("rx_head_77", reg_dat_do, 32'h77);
    pop_n(1);
    pop_n(1);

    // randomized full-duplex traffic
    for (int it = 0; it < 12; it++) begin
      d    = $urandom_range(8, 24);
      tb_b = 8'($urandom);
      rb   = 8'($urandom);
      set_div(d);
      send_tx(tb_b);
      rx_frame(rb, 1'b1, d);
      rx_model_push(rb);
      repeat (d) tick();
      np = $urandom_range(0, 2);
      if (np > 0) pop_n(np);
      chk("rx_overrun_rand", {31'd0, rx_overrun}, {31'd0, exp_ovr});
    end

    // divider of zero behaves as two
    set_div(0);
    chk("div_zero_readback", reg_div_do, 32'd0);
    send_tx(8'h96);
    repeat (30) tick();

    // reset in the middle of a frame
    set_div(16);
    send_tx(8'h00);
    repeat (40) tick();
    chk("tx_low_before_reset", {31'd0, ser_tx}, 32'd0);
    resetn = 1'b0;
    #1;
    chk("rst_mid_ser_tx", {31'd0, ser_tx}, 32'd1);
    chk("rst_mid_div", reg_div_do, 32'd53333);
    chk("rst_mid_dat_do", reg_dat_do, 32'd0);
    chk("rst_mid_ovr", {31'd0, rx_overrun}, 32'd0);
    rxq.delete();
    exp_ovr = 1'b0;
    cur_div = 53333;
    @(posedge clk);
    #1 resetn = 1'b1;
    repeat (200) tick();
    set_div(16);
    send_tx(8'hC3);
    repeat (170) tick();
    chk("tx_queue_drained", txq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
